plugin_pixel_batch_dma: RTL and testbench

//  Upstream feeder for the pixel processor: walks a buffer of RGB pixels (0xRRGGBBXX) in memory,

---
 rtl/plugin_pixel_batch_dma_if.sv | 30 +++
 rtl/plugin_pixel_batch_dma.sv | 147 ++++++++++++++
 tb/tb_plugin_pixel_batch_dma.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plugin_pixel_batch_dma_if.sv
// Memory-port and pixel-processor signals of the pixel batch DMA, grouped for the master (DMA)
// and slave (memory + processor) sides.
interface plugin_pixel_batch_dma_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        proc_start_o;
  logic [31:0] proc_rgb_o;
  logic        proc_busy_i;
  logic        proc_done_i;
  logic [31:0] proc_gray_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output proc_start_o, proc_rgb_o,
    input  proc_busy_i, proc_done_i, proc_gray_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  proc_start_o, proc_rgb_o,
    output proc_busy_i, proc_done_i, proc_gray_i
  );
endinterface

// File: rtl/plugin_pixel_batch_dma.sv
// Batch feeder: reads RGB pixels, runs each through the pixel processor, writes the gray result.
// One memory transaction outstanding at a time; request signals held until granted.
module plugin_pixel_batch_dma #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [CNT_WIDTH-1:0] count_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [CNT_WIDTH-1:0] progress_o,
  plugin_pixel_batch_dma_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, P_START, P_ARM, P_WAIT, WR_REQ, FIN
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] prog_q, prog_d;
  logic [CNT_WIDTH-1:0] prog_inc;
  logic [31:0]          rgb_q, rgb_d;
  logic [31:0]          gray_q, gray_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;

  assign prog_inc       = prog_q + 1'b1;
  assign busy_o         = (state_q != IDLE) && (state_q != FIN);
  assign error_o        = err_q;
  assign progress_o     = prog_q;
  assign bus.proc_rgb_o = rgb_q;

  always_comb begin
    state_d              = state_q;
    src_d                = src_q;
    dst_d                = dst_q;
    cnt_d                = cnt_q;
    prog_d               = prog_q;
    rgb_d                = rgb_q;
    gray_d               = gray_q;
    tmo_d                = tmo_q;
    err_d                = err_q;
    done_o               = 1'b0;
    bus.mem_req_o        = 1'b0;
    bus.mem_we_o         = 1'b0;
    bus.mem_addr_o       = '0;
    bus.mem_wdata_o      = '0;
    bus.proc_start_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          cnt_d   = count_i;
          prog_d  = '0;
          err_d   = 1'b0;
          state_d = (count_i == '0) ? FIN : RD_REQ;
        end
      end
      RD_REQ: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = src_q;
        if (bus.mem_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.mem_rvalid_i) begin
          rgb_d   = bus.mem_rdata_i;
          state_d = P_START;
        end
      end
      P_START: begin
        bus.proc_start_o = 1'b1;
        state_d          = P_ARM;
      end
      // Dead cycle so a done level left over from the previous pixel is not taken as ours.
      P_ARM: begin
        tmo_d   = '0;
        state_d = P_WAIT;
      end
      P_WAIT: begin
        if (bus.proc_done_i && !bus.proc_busy_i) begin
          gray_d  = bus.proc_gray_i;
          state_d = WR_REQ;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WR_REQ: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = dst_q;
        bus.mem_wdata_o = gray_q;
        if (bus.mem_gnt_i) begin
          prog_d  = prog_inc;
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          state_d = (prog_inc == cnt_q) ? FIN : RD_REQ;
        end
      end
      FIN: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      prog_q  <= '0;
      rgb_q   <= '0;
      gray_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      prog_q  <= prog_d;
      rgb_q   <= rgb_d;
      gray_q  <= gray_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_plugin_pixel_batch_dma.sv
// Directed bench for plugin_pixel_batch_dma: memory and processor models on the slave side,
// one task per scenario with hand-computed expectations.
module tb_plugin_pixel_batch_dma;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] count_i = '0;
  logic        busy_o, done_o, error_o;
  logic [15:0] progress_o;

  plugin_pixel_batch_dma_if bus();

  plugin_pixel_batch_dma #(.CNT_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i), .count_i(count_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .progress_o(progress_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model: combinational grant gated per direction, read data one cycle after grant.
  logic        gnt_rd_ok = 1'b1;
  logic        gnt_wr_ok = 1'b1;
  logic [31:0] mem [0:255];
  logic [31:0] rd_addr [$];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          done_cnt = 0;

  assign bus.mem_gnt_i = bus.mem_req_o & (bus.mem_we_o ? gnt_wr_ok : gnt_rd_ok);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_rvalid_i <= 1'b0;
      bus.mem_rdata_i  <= '0;
    end else begin
      bus.mem_rvalid_i <= bus.mem_req_o & bus.mem_gnt_i & ~bus.mem_we_o;
      bus.mem_rdata_i  <= mem[bus.mem_addr_o[9:2]];
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        if (bus.mem_we_o) begin
          wr_addr.push_back(bus.mem_addr_o);
          wr_data.push_back(bus.mem_wdata_o);
        end else begin
          rd_addr.push_back(bus.mem_addr_o);
        end
      end
    end
  end

  // Processor model: 3 cycles busy, then a done pulse; result is the pixel with its low byte cleared.
  logic proc_en = 1'b1;
  int   proc_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.proc_busy_i <= 1'b0;
      bus.proc_done_i <= 1'b0;
      bus.proc_gray_i <= '0;
      proc_cnt        <= 0;
    end else begin
      bus.proc_done_i <= 1'b0;
      if (bus.proc_start_o && proc_en) begin
        bus.proc_busy_i <= 1'b1;
        proc_cnt        <= 3;
      end else if (bus.proc_busy_i) begin
        proc_cnt <= proc_cnt - 1;
        if (proc_cnt == 1) begin
          bus.proc_busy_i <= 1'b0;
          bus.proc_done_i <= 1'b1;
          bus.proc_gray_i <= bus.proc_rgb_o & 32'hFFFF_FF00;
        end
      end
    end
  end

  always @(negedge clk) if (done_o) done_cnt <= done_cnt + 1;

  task automatic clear_logs();
    rd_addr.delete();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic kick(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] cnt);
    @(negedge clk);
    src_addr_i = src;
    dst_addr_i = dst;
    count_i    = cnt;
    start_i    = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (done_o) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL reset_error got %b want 0", error_o); end
    n_cmp++; if (progress_o !== 16'd0) begin n_err++; $display("FAIL reset_progress got %0d want 0", progress_o); end
    n_cmp++; if ({bus.mem_req_o, bus.mem_we_o, bus.proc_start_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl got %b want 000", {bus.mem_req_o, bus.mem_we_o, bus.proc_start_o}); end
    n_cmp++; if ({bus.mem_addr_o, bus.mem_wdata_o, bus.proc_rgb_o} !== 96'd0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {bus.mem_addr_o, bus.mem_wdata_o, bus.proc_rgb_o}); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    logic [31:0] exp_ra [3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] exp_wa [3] = '{32'h200, 32'h204, 32'h208};
    logic [31:0] exp_wd [3] = '{32'hFF00_0000, 32'h00FF_0000, 32'h0000_FF00};
    mem[64] = 32'hFF00_0000; mem[65] = 32'h00FF_0000; mem[66] = 32'h0000_FF00;
    clear_logs();
    kick(32'h100, 32'h200, 16'd3);
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", busy_o); end
    wait_done(300, cyc);
    n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL basic_timeout got no done want done"); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_busy_fin got %b want 0", busy_o); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_addr.size() != 3 || wr_addr.size() != 3) begin
      n_err++; $display("FAIL basic_txn_count got %0d rd %0d wr want 3 3", rd_addr.size(), wr_addr.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (rd_addr[i] !== exp_ra[i]) begin n_err++; $display("FAIL basic_rd_addr%0d got %h want %h", i, rd_addr[i], exp_ra[i]); end
        n_cmp++; if (wr_addr[i] !== exp_wa[i]) begin n_err++; $display("FAIL basic_wr_addr%0d got %h want %h", i, wr_addr[i], exp_wa[i]); end
        n_cmp++; if (wr_data[i] !== exp_wd[i]) begin n_err++; $display("FAIL basic_wr_data%0d got %h want %h", i, wr_data[i], exp_wd[i]); end
      end
    end
    n_cmp++; if (progress_o !== 16'd3) begin n_err++; $display("FAIL basic_progress got %0d want 3", progress_o); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL basic_error got %b want 0", error_o); end
  endtask

  task automatic test_count_zero();
    int cyc;
    bit req_seen = 0;
    clear_logs();
    kick(32'h100, 32'h200, 16'd0);
    cyc = -1;
    for (int i = 1; i <= 4 && cyc < 0; i++) begin
      @(negedge clk);
      if (bus.mem_req_o) req_seen = 1;
      if (done_o) cyc = i;
    end
    n_cmp++; if (cyc < 1 || cyc > 2) begin n_err++; $display("FAIL zero_done_latency got %0d want 1..2", cyc); end
    repeat (3) @(negedge clk);
    n_cmp++; if (req_seen || rd_addr.size() != 0 || wr_addr.size() != 0) begin
      n_err++; $display("FAIL zero_mem_req got %0d rd %0d wr want none", rd_addr.size(), wr_addr.size()); end
    n_cmp++; if (progress_o !== 16'd0) begin n_err++; $display("FAIL zero_progress got %0d want 0", progress_o); end
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL zero_error got %b want 0", error_o); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL zero_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic stall_one(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    int i;
    for (i = 0; i < 100 && !(bus.mem_req_o && bus.mem_we_o == we); i++) @(negedge clk);
    n_cmp++; if (i == 100) begin n_err++; $display("FAIL stall_req_we%0d got no request want request", we); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== we || bus.mem_addr_o !== addr ||
          (we && bus.mem_wdata_o !== wd)) begin
        n_err++;
        $display("FAIL stall_hold_we%0d_c%0d got req %b we %b addr %h wdata %h want 1 %b %h %h",
                 we, k, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, we, addr, wd);
      end
      @(negedge clk);
    end
    if (we) gnt_wr_ok = 1'b1; else gnt_rd_ok = 1'b1;
    @(posedge clk);
    #1 if (we) gnt_wr_ok = 1'b0; else gnt_rd_ok = 1'b0;
  endtask

  task automatic test_stall();
    int cyc;
    mem[72] = 32'h1234_5678;
    clear_logs();
    gnt_rd_ok = 1'b0; gnt_wr_ok = 1'b0;
    kick(32'h120, 32'h300, 16'd1);
    stall_one(1'b0, 32'h120, 32'h0);
    stall_one(1'b1, 32'h300, 32'h1234_5600);
    wait_done(100, cyc);
    gnt_rd_ok = 1'b1; gnt_wr_ok = 1'b1;
    n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL stall_timeout got no done want done"); end
    repeat (2) @(negedge clk);
    n_cmp++; if (rd_addr.size() != 1 || wr_addr.size() != 1) begin
      n_err++; $display("FAIL stall_txn_count got %0d rd %0d wr want 1 1", rd_addr.size(), wr_addr.size()); end
    else begin
      n_cmp++; if (wr_data[0] !== 32'h1234_5600) begin n_err++; $display("FAIL stall_wr_data got %h want 12345600", wr_data[0]); end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    clear_logs();
    kick(32'h100, 32'h500, 16'd3);
    repeat (4) @(negedge clk);
    kick(32'h800, 32'h900, 16'd1);
    wait_done(300, cyc);
    n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL ignore_timeout got no done want done"); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_addr.size() != 3 || wr_addr.size() != 3) begin
      n_err++; $display("FAIL ignore_txn_count got %0d rd %0d wr want 3 3", rd_addr.size(), wr_addr.size()); end
    else begin
      n_cmp++; if (rd_addr[2] !== 32'h108) begin n_err++; $display("FAIL ignore_rd_addr2 got %h want 108", rd_addr[2]); end
      n_cmp++; if (wr_addr[2] !== 32'h508) begin n_err++; $display("FAIL ignore_wr_addr2 got %h want 508", wr_addr[2]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ignore_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_timeout();
    int cyc;
    clear_logs();
    proc_en = 1'b0;
    kick(32'h100, 32'h400, 16'd2);
    wait_done(100, cyc);
    n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL tmo_no_done got no done want done"); end
    n_cmp++; if (error_o !== 1'b1) begin n_err++; $display("FAIL tmo_error got %b want 1", error_o); end
    repeat (3) @(negedge clk);
    n_cmp++; if (error_o !== 1'b1) begin n_err++; $display("FAIL tmo_error_sticky got %b want 1", error_o); end
    n_cmp++; if (wr_addr.size() != 0 || rd_addr.size() != 1) begin
      n_err++; $display("FAIL tmo_txn_count got %0d rd %0d wr want 1 0", rd_addr.size(), wr_addr.size()); end
    n_cmp++; if (progress_o !== 16'd0) begin n_err++; $display("FAIL tmo_progress got %0d want 0", progress_o); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL tmo_done_pulses got %0d want 1", done_cnt); end
    proc_en = 1'b1;
    kick(32'h100, 32'h400, 16'd0);
    n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL tmo_error_clear got %b want 0", error_o); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midbatch();
    int i;
    int cyc;
    clear_logs();
    gnt_wr_ok = 1'b0;
    kick(32'h100, 32'h600, 16'd3);
    for (i = 0; i < 100 && !(bus.mem_req_o && bus.mem_we_o); i++) @(negedge clk);
    n_cmp++; if (i == 100) begin n_err++; $display("FAIL rst_no_wr_req got no write request want request"); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req_async got %b want 0", bus.mem_req_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy_o); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    gnt_wr_ok = 1'b1;
    @(negedge clk);
    n_cmp++; if (done_cnt != 0 || wr_addr.size() != 0) begin
      n_err++; $display("FAIL rst_no_done got %0d done %0d wr want 0 0", done_cnt, wr_addr.size()); end
    clear_logs();
    kick(32'h100, 32'h600, 16'd3);
    wait_done(300, cyc);
    n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL rst_rerun_timeout got no done want done"); end
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_addr.size() != 3) begin n_err++; $display("FAIL rst_rerun_writes got %0d want 3", wr_addr.size()); end
    else begin
      n_cmp++; if (wr_addr[0] !== 32'h600 || wr_data[1] !== 32'h00FF_0000) begin
        n_err++; $display("FAIL rst_rerun_data got %h %h want 00000600 00ff0000", wr_addr[0], wr_data[1]); end
    end
    n_cmp++; if (progress_o !== 16'd3 || error_o !== 1'b0 || done_cnt != 1) begin
      n_err++; $display("FAIL rst_rerun_status got prog %0d err %b done %0d want 3 0 1", progress_o, error_o, done_cnt); end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    test_reset();
    test_basic();
    test_count_zero();
    test_stall();
    test_start_ignored();
    test_timeout();
    test_reset_midbatch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
